// File: rtl/fir_if.sv
// Bus bundle for the FIR accelerator: AXI-Lite control, AXI-Stream in/out,
// and the two single-port BRAM ports.
//
// Handshake semantics (all channels): a transfer happens on the rising edge
// where valid and ready are both high. The source holds valid and its payload
// stable until that edge. Ready may depend on valid.
interface fir_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    logic                   awvalid, awready;
    logic [pADDR_WIDTH-1:0] awaddr;
    logic                   wvalid, wready;
    logic [pDATA_WIDTH-1:0] wdata;
    logic                   arvalid, arready;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   rready, rvalid;
    logic [pDATA_WIDTH-1:0] rdata;

    logic                   ss_tvalid, ss_tlast, ss_tready;
    logic [pDATA_WIDTH-1:0] ss_tdata;
    logic                   sm_tready, sm_tvalid, sm_tlast;
    logic [pDATA_WIDTH-1:0] sm_tdata;

    logic [3:0]             tap_WE, data_WE;
    logic                   tap_EN, data_EN;
    logic [pDATA_WIDTH-1:0] tap_Di, tap_Do, data_Di, data_Do;
    logic [pADDR_WIDTH-1:0] tap_A, data_A;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
               ss_tvalid, ss_tdata, ss_tlast, sm_tready, tap_Do, data_Do,
        output awready, wready, arready, rvalid, rdata, ss_tready,
               sm_tvalid, sm_tdata, sm_tlast,
               tap_WE, tap_EN, tap_Di, tap_A, data_WE, data_EN, data_Di, data_A
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
               ss_tvalid, ss_tdata, ss_tlast, sm_tready, tap_Do, data_Do,
        input  awready, wready, arready, rvalid, rdata, ss_tready,
               sm_tvalid, sm_tdata, sm_tlast,
               tap_WE, tap_EN, tap_Di, tap_A, data_WE, data_EN, data_Di, data_A
    );
endinterface

// File: rtl/fir_filter.sv
// 11-tap FIR accelerator. Coefficients and a circular sample history live in
// external single-port BRAMs (1-cycle read latency). One sample is processed
// at a time: accept, 11 MAC steps, present the result, repeat.
module fir_filter #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic       axis_clk,
    input  logic       axis_rst_n,
    fir_if.slave       bus,
    output logic [2:0] fsm_state
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_WAIT_IN = 3'd2,
        S_MAC     = 3'd3,
        S_OUT     = 3'd4
    } state_t;

    localparam int                     IW       = pADDR_WIDTH - 2;
    localparam logic [3:0]             LAST_TAP = 4'(Tape_Num - 1);
    localparam logic [3:0]             MAC_END  = 4'(Tape_Num);
    localparam logic [IW-1:0]          TAP_BASE = IW'(8);             // 0x20
    localparam logic [IW-1:0]          TAP_END  = IW'(8 + Tape_Num);
    localparam logic [pADDR_WIDTH-1:0] A_CTRL   = pADDR_WIDTH'('h00);
    localparam logic [pADDR_WIDTH-1:0] A_LEN    = pADDR_WIDTH'('h10);

    state_t state, state_nx;

    logic                   ap_start, ap_done, ap_idle;
    logic [pDATA_WIDTH-1:0] data_length;
    logic [3:0]             clr_cnt, mac_cnt, ptr, didx;
    logic [pDATA_WIDTH-1:0] acc, prod, out_cnt, sm_data_q, reg_rdata;
    logic                   aw_go, ar_go, rd_tap_pend, rd_busy;
    logic                   aw_tap, ar_tap, aw_ok, ar_ok, last_out;
    logic                   unused_ss_tlast;

    function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
        return (a[pADDR_WIDTH-1:2] >= TAP_BASE) && (a[pADDR_WIDTH-1:2] < TAP_END);
    endfunction

    function automatic logic [pADDR_WIDTH-1:0] tap_addr(input logic [pADDR_WIDTH-1:0] a);
        return {a[pADDR_WIDTH-1:2] - TAP_BASE, 2'b00};
    endfunction

    assign unused_ss_tlast = bus.ss_tlast;
    assign fsm_state       = state;
    assign ap_idle         = (state == S_IDLE);
    assign aw_tap          = is_tap(bus.awaddr);
    assign ar_tap          = is_tap(bus.araddr);
    assign last_out        = (out_cnt + 32'd1 == data_length);
    // Low 32 bits of a signed product equal those of the unsigned product.
    assign prod            = bus.tap_Do * bus.data_Do;
    assign rd_busy         = ar_go || rd_tap_pend || bus.rvalid;

    // A tap access granted now is performed next cycle, so it is refused if the
    // engine will be in a MAC step then. A simultaneous tap write wins over a read.
    assign aw_ok = bus.awvalid && bus.wvalid && !aw_go && !(aw_tap && state_nx == S_MAC);
    assign ar_ok = bus.arvalid && !rd_busy && !(ar_tap && state_nx == S_MAC) &&
                   !(ar_tap && aw_ok && aw_tap);

    assign bus.awready = aw_go;
    assign bus.wready  = aw_go;
    assign bus.arready = ar_go;
    assign bus.sm_tdata = sm_data_q;

    // Register-file read mux for non-tap addresses.
    always_comb begin
        reg_rdata = '0;
        if (bus.araddr == A_CTRL)
            reg_rdata = pDATA_WIDTH'({ap_idle, ap_done, ap_start});
        else if (bus.araddr == A_LEN)
            reg_rdata = data_length;
    end

    // AXI-Lite handshakes, read data path and control/status registers.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            aw_go       <= 1'b0;
            ar_go       <= 1'b0;
            rd_tap_pend <= 1'b0;
            bus.rvalid  <= 1'b0;
            bus.rdata   <= '0;
            data_length <= '0;
            ap_start    <= 1'b0;
            ap_done     <= 1'b0;
        end else begin
            aw_go       <= aw_ok;
            ar_go       <= ar_ok;
            rd_tap_pend <= ar_go && ar_tap;
            if (ar_go && !ar_tap) begin
                bus.rvalid <= 1'b1;
                bus.rdata  <= reg_rdata;
            end else if (rd_tap_pend) begin
                bus.rvalid <= 1'b1;
                bus.rdata  <= bus.tap_Do;
            end else if (bus.rvalid && bus.rready) begin
                bus.rvalid <= 1'b0;
            end
            if (aw_go && bus.awaddr == A_LEN)
                data_length <= bus.wdata;
            if (state == S_IDLE && ap_start) begin
                ap_start <= 1'b0;
                ap_done  <= 1'b0;
            end else begin
                if (aw_go && bus.awaddr == A_CTRL && bus.wdata[0] && state == S_IDLE)
                    ap_start <= 1'b1;
                if (state == S_OUT && bus.sm_tready && last_out)
                    ap_done <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) state <= S_IDLE;
        else             state <= state_nx;
    end

    // FSM next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (ap_start) state_nx = S_CLEAR;
            S_CLEAR:   if (clr_cnt == LAST_TAP) state_nx = S_WAIT_IN;
            S_WAIT_IN: if (bus.ss_tvalid) state_nx = S_MAC;
            S_MAC:     if (mac_cnt == MAC_END) state_nx = S_OUT;
            S_OUT:     if (bus.sm_tready) state_nx = last_out ? S_IDLE : S_WAIT_IN;
            default:   state_nx = S_IDLE;
        endcase
    end

    // FSM outputs: stream handshakes and BRAM port control.
    always_comb begin
        bus.ss_tready = 1'b0;
        bus.sm_tvalid = 1'b0;
        bus.sm_tlast  = 1'b0;
        bus.data_EN   = 1'b0;
        bus.data_WE   = 4'h0;
        bus.data_A    = '0;
        bus.data_Di   = '0;
        bus.tap_EN    = 1'b0;
        bus.tap_WE    = 4'h0;
        bus.tap_A     = '0;
        bus.tap_Di    = '0;
        case (state)
            S_CLEAR: begin
                bus.data_EN = 1'b1;
                bus.data_WE = 4'hF;
                bus.data_A  = pADDR_WIDTH'({clr_cnt, 2'b00});
            end
            S_WAIT_IN: begin
                bus.ss_tready = bus.ss_tvalid;
                bus.data_EN   = bus.ss_tvalid;
                bus.data_WE   = bus.ss_tvalid ? 4'hF : 4'h0;
                bus.data_A    = pADDR_WIDTH'({ptr, 2'b00});
                bus.data_Di   = bus.ss_tdata;
            end
            S_MAC: begin
                if (mac_cnt < MAC_END) begin
                    bus.data_EN = 1'b1;
                    bus.data_A  = pADDR_WIDTH'({didx, 2'b00});
                    bus.tap_EN  = 1'b1;
                    bus.tap_A   = pADDR_WIDTH'({mac_cnt, 2'b00});
                end
            end
            S_OUT: begin
                bus.sm_tvalid = 1'b1;
                bus.sm_tlast  = last_out;
            end
            default: ;
        endcase
        if (state != S_MAC) begin
            if (aw_go && aw_tap) begin
                bus.tap_EN = 1'b1;
                bus.tap_WE = 4'hF;
                bus.tap_A  = tap_addr(bus.awaddr);
                bus.tap_Di = bus.wdata;
            end else if (ar_go && ar_tap) begin
                bus.tap_EN = 1'b1;
                bus.tap_A  = tap_addr(bus.araddr);
            end
        end
    end

    // Datapath: clear counter, history pointer, MAC pipeline and output count.
    // In MAC step c the BRAMs return operands addressed in step c-1.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            clr_cnt   <= '0;
            mac_cnt   <= '0;
            ptr       <= '0;
            didx      <= '0;
            acc       <= '0;
            out_cnt   <= '0;
            sm_data_q <= '0;
        end else begin
            case (state)
                S_IDLE: clr_cnt <= '0;
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 4'd1;
                    ptr     <= '0;
                    out_cnt <= '0;
                end
                S_WAIT_IN: begin
                    if (bus.ss_tvalid) begin
                        mac_cnt <= '0;
                        didx    <= ptr;
                        acc     <= '0;
                    end
                end
                S_MAC: begin
                    mac_cnt <= mac_cnt + 4'd1;
                    if (mac_cnt < MAC_END)
                        didx <= (didx == 4'd0) ? LAST_TAP : didx - 4'd1;
                    if (mac_cnt != 4'd0)
                        acc <= acc + prod;
                    if (mac_cnt == MAC_END) begin
                        sm_data_q <= acc + prod;
                        ptr       <= (ptr == LAST_TAP) ? 4'd0 : ptr + 4'd1;
                    end
                end
                S_OUT: if (bus.sm_tready) out_cnt <= out_cnt + 32'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter: AXI-Lite register/tap access, impulse,
// step and random streams with output back-pressure, restart, mid-run reset.
module tb_fir_filter;
    localparam int NT    = 11;
    localparam int LIMIT = 3000;

    logic       axis_clk = 1'b0;
    logic       axis_rst_n;
    logic [2:0] fsm_state;

    fir_if bus ();

    fir_filter u_dut (
        .axis_clk  (axis_clk),
        .axis_rst_n(axis_rst_n),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // Clock.
    always #5 axis_clk = ~axis_clk;

    // Single-port BRAM models, 1-cycle read latency.
    logic [31:0] tap_mem  [0:1023];
    logic [31:0] data_mem [0:1023];
    always @(posedge axis_clk) begin
        if (bus.tap_EN) begin
            if (bus.tap_WE == 4'hF) tap_mem[bus.tap_A[11:2]] <= bus.tap_Di;
            bus.tap_Do <= tap_mem[bus.tap_A[11:2]];
        end
        if (bus.data_EN) begin
            if (bus.data_WE == 4'hF) data_mem[bus.data_A[11:2]] <= bus.data_Di;
            bus.data_Do <= data_mem[bus.data_A[11:2]];
        end
    end

    int          n_checks = 0;
    int          n_errors = 0;
    int          taps [NT];
    int          xs [$];
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        axis_rst_n = 1'b0;
        repeat (3) @(negedge axis_clk);
        axis_rst_n = 1'b1;
        @(negedge axis_clk);
    endtask

    task automatic axil_write(input logic [11:0] a, input logic [31:0] d);
        int t = 0;
        @(negedge axis_clk);
        bus.awvalid = 1'b1; bus.awaddr = a; bus.wvalid = 1'b1; bus.wdata = d;
        @(negedge axis_clk);
        while (!(bus.awready && bus.wready) && t < LIMIT) begin
            @(negedge axis_clk);
            t++;
        end
        if (t >= LIMIT) check("aw_timeout", t, 0);
        @(posedge axis_clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    endtask

    task automatic axil_read(input logic [11:0] a, output logic [31:0] d, output int lat);
        int t = 0;
        @(negedge axis_clk);
        bus.arvalid = 1'b1; bus.araddr = a; bus.rready = 1'b0;
        @(negedge axis_clk);
        while (!bus.arready && t < LIMIT) begin
            @(negedge axis_clk);
            t++;
        end
        if (t >= LIMIT) check("ar_timeout", t, 0);
        @(posedge axis_clk); #1;
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        lat = 0;
        do begin
            @(negedge axis_clk);
            lat++;
        end while (!bus.rvalid && lat < LIMIT);
        d = bus.rdata;
        @(posedge axis_clk); #1;
        bus.rready = 1'b0;
    endtask

    task automatic write_taps();
        for (int k = 0; k < NT; k++) axil_write(12'h020 + 12'(4 * k), taps[k]);
    endtask

    // Reference: direct convolution with zero history, 32-bit wraparound.
    task automatic build_expected(input int len);
        exp_q.delete();
        for (int n = 0; n < len; n++) begin
            int acc = 0;
            for (int k = 0; k < NT; k++)
                if (n - k >= 0) acc += taps[k] * xs[n - k];
            exp_q.push_back(acc);
        end
    endtask

    // Drives xs[0..len-1] and checks outputs against exp_q under random back-pressure.
    task automatic run_stream(input int len, input int rdy_pct);
        int viol = 0;
        fork
            begin
                for (int i = 0; i < len; i++) begin
                    int t = 0;
                    repeat ($urandom_range(0, 2)) @(negedge axis_clk);
                    @(negedge axis_clk);
                    bus.ss_tvalid = 1'b1; bus.ss_tdata = xs[i];
                    #1;
                    while (!bus.ss_tready && t < LIMIT) begin
                        @(negedge axis_clk); #1;
                        t++;
                    end
                    if (t >= LIMIT) begin
                        check("ss_timeout", t, 0);
                        i = len;
                    end
                    @(posedge axis_clk); #1;
                    bus.ss_tvalid = 1'b0;
                end
            end
            begin
                int          got = 0;
                int          cyc = 0;
                logic        stalled = 1'b0;
                logic [31:0] held_d = '0;
                logic        held_l = 1'b0;
                logic [31:0] e;
                while (got < len && cyc < LIMIT * 20) begin
                    @(negedge axis_clk);
                    cyc++;
                    if (bus.ss_tready && bus.sm_tvalid) viol++;
                    if (stalled && !bus.sm_tvalid) begin
                        check("stall_valid", 0, 1);
                        stalled = 1'b0;
                    end
                    if (bus.sm_tvalid) begin
                        if (stalled) begin
                            check("stall_data", bus.sm_tdata, held_d);
                            check("stall_last", bus.sm_tlast, held_l);
                        end
                        bus.sm_tready = ($urandom_range(0, 99) < rdy_pct);
                        if (bus.sm_tready) begin
                            e = exp_q.pop_front();
                            check($sformatf("y[%0d]", got), bus.sm_tdata, e);
                            check($sformatf("tlast[%0d]", got), bus.sm_tlast, (got + 1 == len));
                            got++;
                            stalled = 1'b0;
                        end else begin
                            stalled = 1'b1;
                            held_d  = bus.sm_tdata;
                            held_l  = bus.sm_tlast;
                        end
                    end else begin
                        bus.sm_tready = 1'b0;
                    end
                end
                if (got < len) check("out_timeout", got, len);
                @(negedge axis_clk);
                bus.sm_tready = 1'b0;
            end
        join
        check("ss_tready_excl", viol, 0);
    endtask

    // Polls ap_ctrl until done, then confirms no further samples are accepted.
    task automatic finish_run(input string tag);
        logic [31:0] r;
        int          lat;
        int          n = 0;
        int          acc_cnt = 0;
        do begin
            axil_read(12'h000, r, lat);
            n++;
        end while (!r[1] && n < 50);
        check({tag, "_ap_ctrl"}, r, 32'h6);
        @(negedge axis_clk);
        bus.ss_tvalid = 1'b1;
        repeat (6) begin
            #1;
            if (bus.ss_tready) acc_cnt++;
            @(negedge axis_clk);
        end
        bus.ss_tvalid = 1'b0;
        check({tag, "_no_accept"}, acc_cnt, 0);
    endtask

    // Watchdog.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Main sequence.
    initial begin
        logic [31:0] r;
        int          lat;
        int          t;
        bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0;
        bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;
        bus.ss_tvalid = 0; bus.ss_tdata = '0; bus.ss_tlast = 0; bus.sm_tready = 0;
        do_reset();

        check("rst_sm_tvalid", bus.sm_tvalid, 0);
        check("rst_sm_tdata", bus.sm_tdata, 0);
        check("rst_sm_tlast", bus.sm_tlast, 0);
        check("rst_ss_tready", bus.ss_tready, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_bram_en", {bus.tap_EN, bus.data_EN}, 0);
        axil_read(12'h000, r, lat);
        check("rst_ap_ctrl", r, 32'h4);
        check("reg_rd_lat", lat, 1);
        axil_read(12'h010, r, lat);
        check("rst_len", r, 0);

        axil_write(12'h010, 600);
        axil_read(12'h010, r, lat);
        check("len_rb", r, 600);
        axil_write(12'h050, 32'hDEAD_BEEF);
        axil_read(12'h050, r, lat);
        check("unmapped_rd", r, 0);

        taps = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
        write_taps();
        for (int k = 0; k < NT; k++) begin
            axil_read(12'h020 + 12'(4 * k), r, lat);
            check($sformatf("tap_rb[%0d]", k), r, taps[k]);
            check($sformatf("tap_rd_lat[%0d]", k), lat, 2);
        end
        axil_read(12'h02C, r, lat);
        check("tap_2c", r, 23);

        // Impulse response.
        xs.delete();
        for (int i = 0; i < 12; i++) xs.push_back(i == 0 ? 1 : 0);
        build_expected(12);
        axil_write(12'h010, 12);
        axil_write(12'h000, 1);
        run_stream(12, 100);
        finish_run("impulse");

        // Step response.
        xs.delete();
        for (int i = 0; i < 12; i++) xs.push_back(1);
        build_expected(12);
        axil_write(12'h010, 12);
        axil_write(12'h000, 1);
        run_stream(12, 100);
        finish_run("step");

        // Random 600 samples with output back-pressure.
        xs.delete();
        for (int i = 0; i < 600; i++) xs.push_back($urandom);
        build_expected(600);
        axil_write(12'h010, 600);
        axil_write(12'h000, 1);
        run_stream(600, 60);
        finish_run("rand600");

        // Restart without reset: ap_start first, then length and taps.
        build_expected(600);
        axil_write(12'h000, 1);
        axil_write(12'h010, 600);
        write_taps();
        run_stream(600, 60);
        finish_run("rerun600");

        // Random full-range coefficients.
        for (int k = 0; k < NT; k++) taps[k] = $urandom;
        write_taps();
        xs.delete();
        for (int i = 0; i < 50; i++) xs.push_back($urandom);
        build_expected(50);
        axil_write(12'h010, 50);
        axil_write(12'h000, 1);
        run_stream(50, 70);
        finish_run("randtaps");

        // Reset in the middle of a MAC sequence.
        axil_write(12'h010, 5);
        axil_write(12'h000, 1);
        @(negedge axis_clk);
        bus.ss_tvalid = 1'b1; bus.ss_tdata = 32'd7;
        t = 0;
        #1;
        while (!bus.ss_tready && t < LIMIT) begin
            @(negedge axis_clk); #1;
            t++;
        end
        if (t >= LIMIT) check("mid_ss_timeout", t, 0);
        @(posedge axis_clk); #1;
        bus.ss_tvalid = 1'b0;
        repeat (3) @(negedge axis_clk);
        axis_rst_n = 1'b0;
        #1;
        check("midrst_sm_tvalid", bus.sm_tvalid, 0);
        check("midrst_bram_en", {bus.tap_EN, bus.data_EN}, 0);
        repeat (2) @(negedge axis_clk);
        axis_rst_n = 1'b1;
        @(negedge axis_clk);
        axil_read(12'h000, r, lat);
        check("midrst_ap_ctrl", r, 32'h4);
        axil_read(12'h010, r, lat);
        check("midrst_len", r, 0);
        axil_read(12'h02C, r, lat);
        check("midrst_tap_kept", r, taps[3]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
